// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef enum logic [1:0] {
        IFID_HOLD  = 2'd0,
        IFID_FLUSH = 2'd1,
        IFID_LOAD  = 2'd2
    } ifid_op_e;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - memory, control and IF/ID bundle of the fetch stage
interface instruction_fetch_if;

    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic [31:0] Address;
    logic [31:0] Instruction;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic        Fault;

    modport master (
        input  Stall,
        input  Redirect,
        input  RedirectTarget,
        input  Instruction,
        output Address,
        output IFID_Instruction,
        output IFID_PCPlus4,
        output IFID_Valid,
        output Fault
    );

    modport slave (
        output Stall,
        output Redirect,
        output RedirectTarget,
        output Instruction,
        input  Address,
        input  IFID_Instruction,
        input  IFID_PCPlus4,
        input  IFID_Valid,
        input  Fault
    );

endinterface

// File: rtl/ifid_register.sv
// rtl/ifid_register.sv - IF/ID pipeline register with hold, flush and load
module ifid_register
    import fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  ifid_op_e    op_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pcplus4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pcplus4_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pcplus4_q;
    logic        valid_q;

    // Load a fetched word, replace it with a bubble, or keep it for a stalled decode
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            instr_q   <= NOP;
            pcplus4_q <= 32'h0;
            valid_q   <= 1'b0;
        end else begin
            case (op_i)
                IFID_LOAD: begin
                    instr_q   <= instr_i;
                    pcplus4_q <= pcplus4_i;
                    valid_q   <= 1'b1;
                end
                IFID_FLUSH: begin
                    instr_q   <= NOP;
                    pcplus4_q <= 32'h0;
                    valid_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign instr_o   = instr_q;
    assign pcplus4_o = pcplus4_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC register, RUN/HALT control and fetch-fault detection
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned MEM_WORDS = 1025
) (
    input  logic                Clk,
    input  logic                Reset_n,
    instruction_fetch_if.master bus
);

    // Bounds are compared at 33 bits so a PC+4 carry-out also counts as out of range
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         fault_q, fault_d;
    ifid_op_e     ifid_op;

    logic [32:0]  seq_sum;
    logic         pc_bad;
    logic         redirect_bad;
    logic         seq_bad;
    logic         fault_event;

    assign seq_sum      = {1'b0, pc_q} + 33'd4;
    // Checking the current PC catches a bad RESET_PC on the first edge after reset
    assign pc_bad       = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} >= MEM_BYTES);
    assign redirect_bad = (bus.RedirectTarget[1:0] != 2'b00) ||
                          ({1'b0, bus.RedirectTarget} >= MEM_BYTES);
    assign seq_bad      = seq_sum >= MEM_BYTES;
    assign fault_event  = (state_q == RUN) &&
                          (pc_bad ||
                           (bus.Redirect && redirect_bad) ||
                           (!bus.Redirect && !bus.Stall && seq_bad));

    // State, PC and sticky fault registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    // Next state and next PC: redirect beats stall, any fault freezes the PC
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (state_q == RUN) begin
            if (fault_event) begin
                state_d = HALT;
            end else if (bus.Redirect) begin
                pc_d = bus.RedirectTarget;
            end else if (!bus.Stall) begin
                pc_d = seq_sum[31:0];
            end
        end
    end

    // IF/ID control and fault flag for the current state and inputs
    always_comb begin
        ifid_op = IFID_HOLD;
        fault_d = fault_q;
        case (state_q)
            RUN: begin
                if (fault_event) begin
                    ifid_op = IFID_FLUSH;
                    fault_d = 1'b1;
                end else if (bus.Redirect) begin
                    ifid_op = IFID_FLUSH;
                end else if (!bus.Stall) begin
                    ifid_op = IFID_LOAD;
                end
            end
            HALT: begin
                ifid_op = IFID_FLUSH;
                fault_d = 1'b1;
            end
            default: ;
        endcase
    end

    ifid_register u_ifid (
        .clk_i     (Clk),
        .rst_n_i   (Reset_n),
        .op_i      (ifid_op),
        .instr_i   (bus.Instruction),
        .pcplus4_i (seq_sum[31:0]),
        .instr_o   (bus.IFID_Instruction),
        .pcplus4_o (bus.IFID_PCPlus4),
        .valid_o   (bus.IFID_Valid)
    );

    assign bus.Address = pc_q;
    assign bus.Fault   = fault_q;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter MEM_WORDS, default 1025, is the instruction-memory depth in 32-bit words.
REQ-003 Port Clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port Reset_n  input  1  is the reset: asynchronous, active-low.
REQ-005 Port Stall  input  1  holds PC and the IF/ID register when high.
REQ-006 Port Redirect  input  1  requests a control-flow change (branch/jump taken).
REQ-007 Port RedirectTarget  input  32  is the byte address of the redirect target.
REQ-008 Port Address  output  32  is the byte address presented to instruction memory; equals PC.
REQ-009 Port Instruction  input  32  is the combinational instruction-memory read data for Address.
REQ-010 Port IFID_Instruction  output  32  is the registered instruction handed to decode.
REQ-011 Port IFID_PCPlus4  output  32  is the registered PC+4 of that instruction.
REQ-012 Port IFID_Valid  output  1  marks IFID_Instruction as a real instruction, not a bubble.
REQ-013 Port Fault  output  1  is a sticky fetch-fault flag.

Function
REQ-014 Address SHALL equal the PC register combinationally; memory word index is Address>>2.
REQ-015 States SHALL be RUN and HALT; reset enters RUN.
REQ-016 RUN, Redirect=0, Stall=0: PC<=PC+4; IF/ID captures Instruction, PC+4, Valid=1 (one-cycle fetch-to-decode latency).
REQ-017 RUN, Stall=1, Redirect=0: PC and all IF/ID outputs SHALL hold.
REQ-018 RUN, Redirect=1 (regardless of Stall): PC<=RedirectTarget; IF/ID flushed to NOP 32'h0000_0000, IFID_PCPlus4 0, Valid=0.
REQ-019 Redirect with RedirectTarget[1:0]!=0 SHALL set Fault, hold PC, flush IF/ID, enter HALT.
REQ-020 In RUN, a sequential advance or redirect whose next PC >= MEM_WORDS*4 SHALL set Fault, hold PC, flush IF/ID, enter HALT; no wrap-around to 0.
REQ-021 HALT: PC held, IFID_Valid=0, IF/ID holds NOP, Fault=1; Stall and Redirect ignored; exit only by reset.
REQ-022 PC+4 arithmetic SHALL be 32-bit unsigned; the check in REQ-020 is performed on the 33-bit sum so carry-out also faults.

Reset
REQ-023 On Reset_n=0, asynchronously: PC=RESET_PC, IFID_Instruction=0, IFID_PCPlus4=0, IFID_Valid=0, Fault=0, state=RUN.
REQ-024 Reset asserted mid-stall, mid-redirect or in HALT SHALL override all; first fetch after release is from RESET_PC.
REQ-025 RESET_PC misaligned or >= MEM_WORDS*4 SHALL raise Fault on the first post-reset edge and enter HALT.

Structure
REQ-026 Shared package fetch_pkg SHALL hold the state enum (RUN, HALT), NOP constant 32'h0000_0000 and default RESET_PC.
REQ-027 The IF/ID register (hold, flush, load) SHALL be a sub-module named ifid_register; PC logic and FSM stay in instruction_fetch.

Verification
REQ-028 Reset release, memory words 0..3 = 0x11,0x22,0x33,0x44, no stall -> Address 0,4,8,12; IFID_Instruction 0x11..0x44 one cycle later, IFID_PCPlus4 4,8,12,16, Valid=1.
REQ-029 Stall high 3 cycles at PC=8 -> Address stays 8, IF/ID holds 0x22/8, then resumes with 0x33.
REQ-030 Redirect=1, Stall=1, target 0x40 at PC=12 -> next Address 0x40, IFID_Valid=0, IFID_Instruction=0; following cycle holds mem[16].
REQ-031 Redirect to 0x42 -> Fault=1, HALT; later Redirect to 0x0 ignored; Reset_n pulse clears Fault and restarts at 0.
REQ-032 MEM_WORDS=4, run from 0 -> after fetching address 12, Fault=1, Address held at 12, Valid=0.
REQ-033 Reset_n asserted asynchronously between edges during a stall -> outputs reach reset values immediately, before the next edge.
